guess_checker: RTL and testbench

- Game-logic stage directly downstream of the word generator.
- Captures the 7-letter ASCII word after reset, accepts one-letter guesses from the input stage and reveals matching positions.
- Counts misses and declares win or loss.
- Drives masked display characters to the display stage.

---
 rtl/guess_checker.sv | 152 +++++++++++++++
 tb/tb_guess_checker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_checker.sv
// Hangman-style game stage: captures a 7-letter word after reset, scores one-letter
// guesses, tracks misses and win/loss, and drives masked characters to the display.
module guess_checker #(
    parameter int MAX_MISSES  = 6,
    parameter int LOAD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] ascii_1,
    input  logic [6:0] ascii_2,
    input  logic [6:0] ascii_3,
    input  logic [6:0] ascii_4,
    input  logic [6:0] ascii_5,
    input  logic [6:0] ascii_6,
    input  logic [6:0] ascii_7,
    input  logic       guess_valid,
    input  logic [6:0] guess_char,
    output logic       guess_ready,
    output logic       result_valid,
    output logic       hit,
    output logic       repeat_g,
    output logic       invalid,
    output logic [6:0] reveal_mask,
    output logic [2:0] misses,
    output logic       win,
    output logic       lose,
    output logic [6:0] disp_1,
    output logic [6:0] disp_2,
    output logic [6:0] disp_3,
    output logic [6:0] disp_4,
    output logic [6:0] disp_5,
    output logic [6:0] disp_6,
    output logic [6:0] disp_7
);

    localparam int CW = 8;
    localparam logic [6:0] BLANK = 7'h5F;

    typedef enum logic [1:0] {S_LOAD, S_PLAY, S_WON, S_LOST} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   load_cnt, load_cnt_nx;
    logic [6:0][6:0] word, word_nx;
    logic [6:0]      mask_nx;
    logic [2:0]      misses_nx;
    logic            rv_nx, hit_nx, rep_nx, inv_nx;

    logic [6:0] folded;
    logic       is_letter;
    logic [6:0] match, new_bits, mask_grown;
    logic [6:0] disp [7];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_LOAD;
            load_cnt     <= '0;
            word         <= '0;
            reveal_mask  <= '0;
            misses       <= '0;
            result_valid <= 1'b0;
            hit          <= 1'b0;
            repeat_g     <= 1'b0;
            invalid      <= 1'b0;
        end else begin
            state        <= state_nx;
            load_cnt     <= load_cnt_nx;
            word         <= word_nx;
            reveal_mask  <= mask_nx;
            misses       <= misses_nx;
            result_valid <= rv_nx;
            hit          <= hit_nx;
            repeat_g     <= rep_nx;
            invalid      <= inv_nx;
        end
    end

    // Lowercase letters fold onto uppercase before comparing against the stored word.
    always_comb begin
        folded = guess_char;
        if (guess_char >= 7'h61 && guess_char <= 7'h7A)
            folded = guess_char - 7'h20;
        is_letter = (folded >= 7'h41) && (folded <= 7'h5A);
        for (int i = 0; i < 7; i++)
            match[i] = (folded == word[i]);
        new_bits   = match & ~reveal_mask;
        mask_grown = reveal_mask | new_bits;
    end

    always_comb begin
        state_nx    = state;
        load_cnt_nx = load_cnt;
        word_nx     = word;
        mask_nx     = reveal_mask;
        misses_nx   = misses;
        rv_nx       = 1'b0;
        hit_nx      = 1'b0;
        rep_nx      = 1'b0;
        inv_nx      = 1'b0;
        unique case (state)
            S_LOAD: begin
                load_cnt_nx = load_cnt + 1'b1;
                if (load_cnt == CW'(LOAD_CYCLES - 1)) begin
                    word_nx  = {ascii_7, ascii_6, ascii_5, ascii_4, ascii_3, ascii_2, ascii_1};
                    state_nx = S_PLAY;
                end
            end
            S_PLAY: begin
                if (guess_valid) begin
                    rv_nx = 1'b1;
                    if (!is_letter) begin
                        inv_nx = 1'b1;
                    end else if (new_bits != 7'd0) begin
                        hit_nx  = 1'b1;
                        mask_nx = mask_grown;
                        if (mask_grown == 7'h7F)
                            state_nx = S_WON;
                    end else if (match != 7'd0) begin
                        rep_nx = 1'b1;
                    end else begin
                        misses_nx = misses + 3'd1;
                        if (misses + 3'd1 == 3'(MAX_MISSES))
                            state_nx = S_LOST;
                    end
                end
            end
            S_WON, S_LOST: ;
            default: state_nx = S_LOAD;
        endcase
    end

    assign guess_ready = (state == S_PLAY);
    assign win         = (state == S_WON);
    assign lose        = (state == S_LOST);

    // A lost game uncovers the whole word; nothing is shown until the word is captured.
    always_comb begin
        for (int i = 0; i < 7; i++) begin
            disp[i] = BLANK;
            if (state == S_LOST || (state != S_LOAD && reveal_mask[i]))
                disp[i] = word[i];
        end
    end

    assign disp_1 = disp[0];
    assign disp_2 = disp[1];
    assign disp_3 = disp[2];
    assign disp_4 = disp[3];
    assign disp_5 = disp[4];
    assign disp_6 = disp[5];
    assign disp_7 = disp[6];

endmodule

// File: tb/tb_guess_checker.sv
// Self-checking bench for guess_checker: a word-level game model compared every cycle,
// plus directed games with hand-computed expectations.
module tb_guess_checker;

    localparam int MAX_MISSES  = 6;
    localparam int LOAD_CYCLES = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] ascii [1:7];
    logic       guess_valid;
    logic [6:0] guess_char;
    logic       guess_ready, result_valid, hit, repeat_g, invalid, win, lose;
    logic [6:0] reveal_mask;
    logic [2:0] misses;
    logic [6:0] disp [1:7];

    int assert_count = 0;
    int fail_count   = 0;
    bit checking     = 1'b0;

    guess_checker #(.MAX_MISSES(MAX_MISSES), .LOAD_CYCLES(LOAD_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .ascii_1(ascii[1]), .ascii_2(ascii[2]), .ascii_3(ascii[3]), .ascii_4(ascii[4]),
        .ascii_5(ascii[5]), .ascii_6(ascii[6]), .ascii_7(ascii[7]),
        .guess_valid(guess_valid), .guess_char(guess_char),
        .guess_ready(guess_ready), .result_valid(result_valid), .hit(hit),
        .repeat_g(repeat_g), .invalid(invalid), .reveal_mask(reveal_mask),
        .misses(misses), .win(win), .lose(lose),
        .disp_1(disp[1]), .disp_2(disp[2]), .disp_3(disp[3]), .disp_4(disp[4]),
        .disp_5(disp[5]), .disp_6(disp[6]), .disp_7(disp[7])
    );

    always #5 clk = ~clk;

    // Game model: the word as letters, a revealed flag per letter, a miss tally.
    int       m_since;
    bit       m_loaded;
    int       m_word [1:7];
    bit       m_rev  [1:7];
    int       m_miss;
    bit       m_rv, m_hit, m_rep, m_inv;

    function automatic bit all_revealed();
        for (int p = 1; p <= 7; p++)
            if (!m_rev[p]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        int g, found, fresh;
        m_rv = 0; m_hit = 0; m_rep = 0; m_inv = 0;
        if (rst) begin
            m_since = 0; m_loaded = 0; m_miss = 0;
            for (int p = 1; p <= 7; p++) begin m_word[p] = 0; m_rev[p] = 0; end
        end else if (!m_loaded) begin
            if (m_since == LOAD_CYCLES - 1) begin
                for (int p = 1; p <= 7; p++) m_word[p] = int'(ascii[p]);
                m_loaded = 1;
            end
            m_since++;
        end else if (!all_revealed() && m_miss < MAX_MISSES && guess_valid) begin
            m_rv = 1;
            g = int'(guess_char);
            if (g >= "a" && g <= "z") g = g - 32;
            if (g < "A" || g > "Z") begin
                m_inv = 1;
            end else begin
                found = 0; fresh = 0;
                for (int p = 1; p <= 7; p++)
                    if (m_word[p] == g) begin
                        found++;
                        if (!m_rev[p]) begin fresh++; m_rev[p] = 1; end
                    end
                if (fresh > 0)      m_hit = 1;
                else if (found > 0) m_rep = 1;
                else                m_miss++;
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle after the first reset, the whole output set is checked against the model.
    always @(posedge clk) begin
        #2;
        if (checking) begin
            int exp_mask, exp_disp;
            bit won, lost;
            won  = m_loaded && all_revealed();
            lost = m_loaded && (m_miss == MAX_MISSES);
            exp_mask = 0;
            for (int p = 1; p <= 7; p++) if (m_rev[p]) exp_mask |= (1 << (p - 1));
            checkOutput("m_guess_ready", guess_ready, int'(m_loaded && !won && !lost));
            checkOutput("m_result_valid", result_valid, m_rv);
            checkOutput("m_hit", hit, m_hit);
            checkOutput("m_repeat", repeat_g, m_rep);
            checkOutput("m_invalid", invalid, m_inv);
            checkOutput("m_mask", reveal_mask, exp_mask);
            checkOutput("m_misses", misses, m_miss);
            checkOutput("m_win", win, won);
            checkOutput("m_lose", lose, lost);
            for (int p = 1; p <= 7; p++) begin
                exp_disp = 'h5F;
                if (m_loaded && (lost || m_rev[p])) exp_disp = m_word[p];
                checkOutput($sformatf("m_disp_%0d", p), disp[p], exp_disp);
            end
        end
    end

    task automatic setWord(input string w);
        for (int p = 1; p <= 7; p++) ascii[p] = w[p-1][6:0];
    endtask

    task automatic applyStimulus(input bit valid, input byte ch);
        @(negedge clk);
        guess_valid = valid;
        guess_char  = ch[6:0];
        @(posedge clk);
        #2;
    endtask

    task automatic startGame(input string w);
        @(negedge clk);
        setWord(w);
        rst = 1; guess_valid = 0;
        @(negedge clk);
        rst = 0;
        repeat (LOAD_CYCLES) @(posedge clk);
        #2;
        checkOutput("start_ready", guess_ready, 1);
    endtask

    initial begin
        string lose_seq, win_seq;
        rst = 1; guess_valid = 0; guess_char = 0;
        setWord("MUSTANG");
        @(posedge clk); #2;
        checking = 1;
        checkOutput("reset_mask", reveal_mask, 0);
        checkOutput("reset_ready", guess_ready, 0);
        checkOutput("reset_disp1", disp[1], 'h5F);

        // Lowercase hit reveals a single position; later word changes are ignored.
        startGame("MUSTANG");
        applyStimulus(1, "t");
        checkOutput("t_valid", result_valid, 1);
        checkOutput("t_hit", hit, 1);
        checkOutput("t_mask", reveal_mask, 'b0001000);
        checkOutput("t_disp4", disp[4], 'h54);
        checkOutput("t_disp3", disp[3], 'h5F);
        checkOutput("t_misses", misses, 0);
        setWord("ZZZZZZZ");
        applyStimulus(0, 0);
        checkOutput("t_pulse_end", result_valid, 0);
        checkOutput("t_disp4_held", disp[4], 'h54);
        applyStimulus(1, "5");
        checkOutput("digit_invalid", invalid, 1);
        checkOutput("digit_misses", misses, 0);
        applyStimulus(0, 0);

        // Duplicate letter reveals both positions, then repeats without penalty.
        startGame("WAFFLES");
        applyStimulus(1, "F");
        checkOutput("ff_mask", reveal_mask, 'b0001100);
        checkOutput("ff_hit", hit, 1);
        applyStimulus(1, "F");
        checkOutput("ff_repeat", repeat_g, 1);
        checkOutput("ff_rep_hit", hit, 0);
        checkOutput("ff_rep_mask", reveal_mask, 'b0001100);
        checkOutput("ff_rep_miss", misses, 0);
        applyStimulus(0, 0);

        // Six straight misses with guess_valid held high.
        startGame("CHANGES");
        lose_seq = "ZQXJVK";
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, lose_seq[i]);
            checkOutput("lose_valid", result_valid, 1);
            checkOutput("lose_misses", misses, i + 1);
            checkOutput("lose_flag", lose, int'(i == 5));
        end
        applyStimulus(1, "C");
        checkOutput("lost_ignored", result_valid, 0);
        checkOutput("lost_disp1", disp[1], "C");
        checkOutput("lost_disp7", disp[7], "S");
        applyStimulus(0, 0);

        // Full word wins on the seventh hit; later guesses are ignored.
        startGame("MUSTANG");
        win_seq = "MUSTANG";
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, win_seq[i]);
            checkOutput("win_flag", win, int'(i == 6));
        end
        checkOutput("win_mask", reveal_mask, 'h7F);
        applyStimulus(1, "5");
        checkOutput("won_ignored", result_valid, 0);
        checkOutput("won_held", win, 1);
        applyStimulus(0, 0);

        // Reset mid-game alongside a guess, with a guess held through LOAD.
        startGame("MUSTANG");
        applyStimulus(1, "T");
        applyStimulus(1, "Z");
        applyStimulus(1, "Q");
        checkOutput("mid_mask", reveal_mask, 'b0001000);
        checkOutput("mid_misses", misses, 2);
        @(negedge clk);
        rst = 1; guess_valid = 1; guess_char = "M";
        setWord("WAFFLES");
        @(posedge clk); #2;
        checkOutput("rst_mask", reveal_mask, 0);
        checkOutput("rst_misses", misses, 0);
        checkOutput("rst_valid", result_valid, 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk); #2;
        checkOutput("load_ignored", result_valid, 0);
        checkOutput("load_ready", guess_ready, 0);
        @(negedge clk);
        guess_valid = 0;
        @(posedge clk); #2;
        checkOutput("reload_ready", guess_ready, 1);
        applyStimulus(1, "w");
        checkOutput("reload_mask", reveal_mask, 'b0000001);
        checkOutput("reload_disp1", disp[1], "W");
        applyStimulus(0, 0);

        repeat (2) @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
